// File: rtl/regwr_pkg.sv
// Shared constants for the register-bank write-port arbiter.
//   ADDR_W / DATA_W / NUM_REGS : default register-bank geometry
//   ZERO_REG                   : hardwired-zero register, never gets a WriteEn
//   REQ_*                      : conventional requester slots
//   GID_W                      : width of the encoded grant index (up to 8 requesters)
//   next_ptr()                 : round-robin pointer successor, wraps at num_req
package regwr_pkg;

  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 2 ** ADDR_W;
  localparam int unsigned ZERO_REG = 0;

  localparam int unsigned REQ_WB     = 0;
  localparam int unsigned REQ_MULDIV = 1;
  localparam int unsigned REQ_DBG    = 2;

  localparam int unsigned GID_W = 3;

  function automatic logic [GID_W-1:0] next_ptr(input logic [GID_W-1:0] idx,
                                                input int unsigned       num_req);
    if (32'(idx) + 32'd1 >= num_req) begin
      return '0;
    end
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Write-request / write-bus bundle for regfile_wr_arbiter.
//   master : requester side (drives req_valid/req_addr/req_data/wr_hold,
//            observes req_ready and the registered write bus)
//   slave  : arbiter side (the reverse)
// Packing: requester i occupies req_addr[i*ADDR_W +: ADDR_W] and
//          req_data[i*DATA_W +: DATA_W].
interface regfile_wr_arbiter_if
  import regwr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      wr_hold;
  logic [NumRegs-1:0]        wr_en;
  logic [DATA_W-1:0]         wr_data;
  logic                      wr_valid;
  logic [GID_W-1:0]          grant_id;

  modport master (
    output req_valid, req_addr, req_data, wr_hold,
    input  req_ready, wr_en, wr_data, wr_valid, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_hold,
    output req_ready, wr_en, wr_data, wr_valid, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   req_i  : request vector
//   ptr_i  : index where the search starts (wraps modulo NUM_REQ)
//   hold_i : suppresses every grant
//   gnt_o  : one-hot grant, idx_o : its encoded index (0 when no grant)
// With REGFILE_WR_ARB_PRIO0_EN defined, request 0 wins outright and the
// round-robin search covers indices 1..NUM_REQ-1 only.
module rr_arbiter
  import regwr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [GID_W-1:0]   ptr_i,
  input  logic               hold_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [GID_W-1:0]   idx_o
);

  logic [NUM_REQ-1:0]   rr_req;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic                 found;
  int unsigned          sum;

  always_comb begin
    rr_req = req_i;
`ifdef REGFILE_WR_ARB_PRIO0_EN
    rr_req[0] = 1'b0;
`endif
  end

  always_comb begin
    // Rotate so the pointer position lands at bit 0; the first set bit is the winner.
    dbl   = {rr_req, rr_req} >> ptr_i;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    idx_o = '0;
    sum   = 0;
`ifdef REGFILE_WR_ARB_PRIO0_EN
    if (req_i[0]) begin
      found = 1'b1;
    end
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = 32'(ptr_i) + k;
        if (sum >= NUM_REQ) begin
          sum = sum - NUM_REQ;
        end
        idx_o = GID_W'(sum);
      end
    end
    if (hold_i) begin
      found = 1'b0;
      idx_o = '0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      gnt_o[i] = found && (idx_o == GID_W'(i));
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the register bank's single write port between NUM_REQ requesters.
//   clk_i  : rising-edge clock
//   rst_ni : asynchronous active-low reset (release is synchronous upstream)
//   bus    : regfile_wr_arbiter_if.slave -- valid/ready requests in, one-hot
//            registered WriteEn, write data, wr_valid and grant_id out
// One transfer per cycle; the accepted write is presented one cycle later.
// Writes to the zero register are accepted but never raise a WriteEn bit.
// Optional build macro: REGFILE_WR_ARB_PRIO0_EN gives requester 0 absolute
// priority; round-robin then rotates among requesters 1..NUM_REQ-1.
module regfile_wr_arbiter
  import regwr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  regfile_wr_arbiter_if.slave bus
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [NUM_REQ-1:0] gnt;
  logic [GID_W-1:0]   gnt_idx;
  logic               arb_hold;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  logic [GID_W-1:0]   ptr_q, ptr_d;
  logic               wr_valid_q, wr_valid_d;
  logic [GID_W-1:0]   grant_id_q, grant_id_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic [NumRegs-1:0] wr_en_q, wr_en_d;

  // Reset gates the grant so req_ready is 0 throughout reset.
  assign arb_hold = bus.wr_hold | ~rst_ni;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i (bus.req_valid),
    .ptr_i (ptr_q),
    .hold_i(arb_hold),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  assign bus.req_ready = gnt;
  assign xfer          = |gnt;

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
`ifdef REGFILE_WR_ARB_PRIO0_EN
    if (xfer && (gnt_idx != '0)) begin
      ptr_d = next_ptr(gnt_idx, NUM_REQ);
    end
`else
    if (xfer) begin
      ptr_d = next_ptr(gnt_idx, NUM_REQ);
    end
`endif
  end

  always_comb begin
    wr_valid_d = xfer;
    grant_id_d = xfer ? gnt_idx : grant_id_q;
    wr_data_d  = xfer ? sel_data : wr_data_q;
    for (int unsigned r = 0; r < NumRegs; r++) begin
      wr_en_d[r] = xfer && (sel_addr == ADDR_W'(r)) && (r != ZERO_REG);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= '0;
      wr_valid_q <= 1'b0;
      grant_id_q <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= '0;
    end else begin
      ptr_q      <= ptr_d;
      wr_valid_q <= wr_valid_d;
      grant_id_q <= grant_id_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
    end
  end

  assign bus.wr_valid = wr_valid_q;
  assign bus.grant_id = grant_id_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.wr_en    = wr_en_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: every cycle the expected grant is
// computed from a round-robin model, the expected presentation is queued, and
// it is popped and compared against the write bus one cycle later.
module tb_regfile_wr_arbiter;

  localparam int unsigned NR = 3;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

  typedef struct {
    logic        valid;
    logic [2:0]  gid;
    logic [31:0] en;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;
  exp_t sb[$];
  logic [31:0] last_data;
  int unsigned mptr;

  regfile_wr_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) bus ();

  regfile_wr_arbiter #(
    .NUM_REQ(NR),
    .DATA_W (DW),
    .ADDR_W (AW)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [NR-1:0] model_grant(input logic [NR-1:0] v, input logic hold,
                                                input int unsigned p);
    int unsigned j;
    if (hold) return '0;
`ifdef REGFILE_WR_ARB_PRIO0_EN
    if (v[0]) return 3'b001;
`endif
    for (int unsigned k = 0; k < NR; k++) begin
      j = (p + k) % NR;
`ifdef REGFILE_WR_ARB_PRIO0_EN
      if (j == 0) continue;
`endif
      if (v[j]) return NR'(1) << j;
    end
    return '0;
  endfunction

  task automatic set_req(input int unsigned i, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr[i*AW +: AW] = a;
    bus.req_data[i*DW +: DW] = d;
  endtask

  // One clock: check last cycle's presentation and this cycle's grant, queue the next.
  task automatic step();
    exp_t o, e;
    logic [NR-1:0] er;
    logic [4:0] a;
    int unsigned g;
    @(negedge clk);
    if (sb.size() == 0) begin
      n_cmp++; n_fail++;
      $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
    end else begin
      o = sb.pop_front();
      n_cmp++;
      if (bus.wr_valid !== o.valid) begin
        n_fail++;
        $display("FAIL wr_valid at %0t: got %b required %b", $time, bus.wr_valid, o.valid);
      end
      n_cmp++;
      if (bus.wr_en !== o.en) begin
        n_fail++;
        $display("FAIL wr_en at %0t: got %h required %h", $time, bus.wr_en, o.en);
      end
      n_cmp++;
      if (bus.wr_data !== o.data) begin
        n_fail++;
        $display("FAIL wr_data at %0t: got %h required %h", $time, bus.wr_data, o.data);
      end
      if (o.valid) begin
        n_cmp++;
        if (bus.grant_id !== o.gid) begin
          n_fail++;
          $display("FAIL grant_id at %0t: got %0d required %0d", $time, bus.grant_id, o.gid);
        end
      end
    end
    er = model_grant(bus.req_valid, bus.wr_hold, mptr);
    n_cmp++;
    if (bus.req_ready !== er) begin
      n_fail++;
      $display("FAIL req_ready at %0t: got %b required %b", $time, bus.req_ready, er);
    end
    e.valid = 1'b0; e.gid = '0; e.en = '0; e.data = last_data;
    for (int unsigned i = 0; i < NR; i++) begin
      if (er[i]) begin
        g = i;
        a = bus.req_addr[i*AW +: AW];
        e.valid = 1'b1;
        e.gid   = 3'(i);
        e.en    = (a == 5'd0) ? 32'd0 : (32'd1 << a);
        e.data  = bus.req_data[i*DW +: DW];
        last_data = e.data;
`ifdef REGFILE_WR_ARB_PRIO0_EN
        if (g != 0) mptr = (g + 1) % NR;
`else
        mptr = (g + 1) % NR;
`endif
      end
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_release(input int cycles);
    exp_t r;
    rst_n = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
    sb.delete();
    r.valid = 1'b0; r.gid = '0; r.en = '0; r.data = '0;
    sb.push_back(r);
    last_data = '0;
    mptr      = 0;
    rst_n     = 1'b1;
  endtask

  task automatic test_reset();
    bus.req_valid = 3'b111;
    set_req(0, 5'd1, 32'h1); set_req(1, 5'd2, 32'h2); set_req(2, 5'd3, 32'h3);
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got %b required 000", bus.req_ready);
    end
    n_cmp++;
    if (bus.wr_en !== 32'd0 || bus.wr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr: got en=%h v=%b required 0/0", bus.wr_en, bus.wr_valid);
    end
    n_cmp++;
    if (bus.wr_data !== 32'd0 || bus.grant_id !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_data: got d=%h g=%0d required 0/0", bus.wr_data, bus.grant_id);
    end
    bus.req_valid = '0;
    reset_release(1);
    step();
  endtask

  task automatic test_single();
    bus.req_valid = 3'b001;
    set_req(0, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b001) begin
      n_fail++; $display("FAIL single_ready: got %b required 001", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.wr_en !== 32'h0000_0020) begin
      n_fail++; $display("FAIL single_wr_en: got %h required 00000020", bus.wr_en);
    end
    step();
    step();
  endtask

  task automatic test_round_robin();
    logic [NR-1:0] want;
    reset_release(2);
    set_req(0, 5'd10, 32'hA000_0000);
    set_req(1, 5'd11, 32'hB111_1111);
    set_req(2, 5'd12, 32'hC222_2222);
    bus.req_valid = 3'b111;
    for (int i = 0; i < 6; i++) begin
      #1;
      want = NR'(1) << (i % 3);
      n_cmp++;
      if (bus.req_ready !== want) begin
        n_fail++; $display("FAIL rr_order[%0d]: got %b required %b", i, bus.req_ready, want);
      end
      step();
    end
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_zero_reg();
    set_req(1, 5'd0, 32'h0000_1234);
    bus.req_valid = 3'b010;
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++; $display("FAIL zero_ready: got %b required 010", bus.req_ready);
    end
    step();
    // The zero-register grant must still advance the pointer to 2.
    set_req(0, 5'd3, 32'h0303_0303);
    set_req(1, 5'd4, 32'h0404_0404);
    set_req(2, 5'd6, 32'h0606_0606);
    bus.req_valid = 3'b111;
    #1;
    n_cmp++;
    if (bus.wr_valid !== 1'b1 || bus.wr_en !== 32'd0 || bus.grant_id !== 3'd1) begin
      n_fail++;
      $display("FAIL zero_present: got v=%b en=%h g=%0d required 1/0/1",
               bus.wr_valid, bus.wr_en, bus.grant_id);
    end
`ifndef REGFILE_WR_ARB_PRIO0_EN
    n_cmp++;
    if (bus.req_ready !== 3'b100) begin
      n_fail++; $display("FAIL zero_ptr: got %b required 100", bus.req_ready);
    end
`endif
    step();
  endtask

  task automatic test_hold();
    bus.req_valid = 3'b111;
    step();
    bus.wr_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 3'b000) begin
        n_fail++; $display("FAIL hold_ready[%0d]: got %b required 000", i, bus.req_ready);
      end
      step();
    end
    bus.wr_hold = 1'b0;
    #1;
`ifndef REGFILE_WR_ARB_PRIO0_EN
    n_cmp++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++; $display("FAIL hold_resume: got %b required 010", bus.req_ready);
    end
`endif
    step();
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_async_reset();
    set_req(0, 5'd7, 32'h7777_0007);
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = '0;
    n_cmp++;
    if (bus.wr_valid !== 1'b1 || bus.wr_en !== 32'h0000_0080) begin
      n_fail++;
      $display("FAIL ares_pre: got v=%b en=%h required 1/00000080", bus.wr_valid, bus.wr_en);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.wr_valid !== 1'b0 || bus.wr_en !== 32'd0) begin
      n_fail++;
      $display("FAIL ares_drop: got v=%b en=%h required 0/0", bus.wr_valid, bus.wr_en);
    end
    reset_release(1);
    // Pointer back at 0: with requesters 0 and 2 pending, 0 wins.
    set_req(2, 5'd9, 32'h9999_0009);
    bus.req_valid = 3'b101;
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b001) begin
      n_fail++; $display("FAIL ares_ptr: got %b required 001", bus.req_ready);
    end
    step();
    step();
    bus.req_valid = '0;
    step();
  endtask

`ifdef REGFILE_WR_ARB_PRIO0_EN
  task automatic test_prio0();
    set_req(0, 5'd1, 32'h1111_0001);
    set_req(1, 5'd2, 32'h2222_0002);
    bus.req_valid = 3'b011;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 3'b001) begin
        n_fail++; $display("FAIL prio0_win[%0d]: got %b required 001", i, bus.req_ready);
      end
      step();
    end
    bus.req_valid = 3'b010;
    #1;
    n_cmp++;
    if (bus.req_ready !== 3'b010) begin
      n_fail++; $display("FAIL prio0_drop: got %b required 010", bus.req_ready);
    end
    step();
    bus.req_valid = '0;
    step();
  endtask
`endif

  initial begin
    n_cmp = 0; n_fail = 0; last_data = '0; mptr = 0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.wr_hold = 1'b0;
    test_reset();
    test_single();
`ifndef REGFILE_WR_ARB_PRIO0_EN
    test_round_robin();
`else
    reset_release(2);
    test_prio0();
`endif
    test_zero_reg();
    test_hold();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
